intc: RTL

- Memory-mapped interrupt controller that consumes the `timeout` lines of timer-style peripherals and presents one `irq` to the CPU.
- Per source it detects rising edges and tracks pending and in-service state.
- The CPU uses a claim/complete handshake over the same `reg_sel`/`rd`/`wr`/tri-state `out` register interface the peripherals use.

---
 rtl/intc_pkg.sv | 6 +
 rtl/intc_src.sv | 39 +++
 rtl/intc.sv | 64 ++++++
 3 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: register map, per-source state encoding and id width for the interrupt controller.
package intc_pkg;
  typedef enum logic [1:0] {PENDING, MASK, CLAIM, COMPLETE} intc_reg_e;
  typedef enum logic [1:0] {IDLE, PEND, SERV, SERV_PEND} intc_src_state_e;
  localparam int INTC_ID_BITS = 5;
endpackage

// File: rtl/intc_src.sv
// intc_src: rising-edge detector plus pending/in-service FSM for one interrupt source.
module intc_src
  import intc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic in_service_o,
  output logic pend_d_o
);
  intc_src_state_e state_q, state_d;
  logic src_q, rise;
  assign rise = src_i & ~src_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rise ? PEND : IDLE;
      PEND:    state_d = claim_i ? (rise ? SERV_PEND : SERV) : PEND;
      SERV:    state_d = complete_i ? (rise ? PEND : IDLE) : (rise ? SERV_PEND : SERV);
      default: state_d = complete_i ? PEND : SERV_PEND;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_i;
    end
  end
  assign pending_o    = (state_q == PEND) || (state_q == SERV_PEND);
  assign in_service_o = (state_q == SERV) || (state_q == SERV_PEND);
  // next-state view lets the top register irq without an extra cycle of lag
  assign pend_d_o     = state_d == PEND;
endmodule

// File: rtl/intc.sv
// intc: memory-mapped interrupt controller with per-source mask, fixed-priority claim
// and claim/complete handshake; source 1 has the highest priority.
module intc
  import intc_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_SRC   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] data,
  input  intc_reg_e            reg_sel,
  output tri   [WORD_SIZE-1:0] out,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [NUM_SRC-1:0]   src,
  output logic                 irq
);
  logic [NUM_SRC-1:0] pending, in_svc, pend_d, claimable, win, claim, complete;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [INTC_ID_BITS-1:0] claim_id;
  logic [WORD_SIZE-1:0] rdata;
  logic irq_q, irq_d, unused_data;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign complete[i] = wr && reg_sel == COMPLETE && data[INTC_ID_BITS-1:0] == INTC_ID_BITS'(i + 1);
    intc_src u_src (
      .clk          (clk),
      .rst_n        (rst_n),
      .src_i        (src[i]),
      .claim_i      (claim[i]),
      .complete_i   (complete[i]),
      .pending_o    (pending[i]),
      .in_service_o (in_svc[i]),
      .pend_d_o     (pend_d[i])
    );
  end
  assign claimable = pending & ~in_svc & mask_q;
  assign win       = claimable & (~claimable + 1'b1);
  assign claim     = (rd && reg_sel == CLAIM) ? win : '0;
  always_comb begin
    claim_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (claimable[i]) claim_id = INTC_ID_BITS'(i + 1);
  end
  assign mask_d = (wr && reg_sel == MASK) ? data[NUM_SRC-1:0] : mask_q;
  assign irq_d  = |(pend_d & mask_d);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end
  always_comb begin
    rdata = reg_sel == PENDING ? WORD_SIZE'(pending) :
            reg_sel == MASK    ? WORD_SIZE'(mask_q)  :
            reg_sel == CLAIM   ? WORD_SIZE'(claim_id) : '0;
  end
  assign out         = rd ? rdata : 'z;
  assign irq         = irq_q;
  assign unused_data = ^data;
endmodule
